// File: rtl/cmac_rate_watchdog.sv
// Rate watchdog behind the CMAC window meter: min/max/moving-average statistics
// plus a hysteresis FSM that flags sustained link starvation.
module cmac_rate_watchdog #(
    parameter int unsigned RATE_WIDTH    = 32,
    parameter int unsigned AVG_LOG2      = 3,
    parameter int unsigned FAIL_COUNT    = 3,
    parameter int unsigned RECOVER_COUNT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RATE_WIDTH-1:0] rate_in,
    input  logic                  rate_valid,
    input  logic [RATE_WIDTH-1:0] thresh_low,
    input  logic                  stats_clear,
    output logic [RATE_WIDTH-1:0] rate_min,
    output logic [RATE_WIDTH-1:0] rate_max,
    output logic [RATE_WIDTH-1:0] rate_avg,
    output logic                  avg_valid,
    output logic [31:0]           sample_cnt,
    output logic [1:0]            state,
    output logic                  alarm,
    output logic                  alarm_rise
);

    localparam int unsigned Depth  = 2 ** AVG_LOG2;
    localparam int unsigned SumW   = RATE_WIDTH + AVG_LOG2;
    localparam int unsigned FillW  = AVG_LOG2 + 1;
    localparam int unsigned MaxRun = (FAIL_COUNT > RECOVER_COUNT) ? FAIL_COUNT : RECOVER_COUNT;
    localparam int unsigned RunW   = $clog2(MaxRun + 1);

    localparam logic [FillW-1:0] FillFull   = FillW'(Depth);
    localparam logic [RunW-1:0]  FailRun    = RunW'(FAIL_COUNT);
    localparam logic [RunW-1:0]  RecoverRun = RunW'(RECOVER_COUNT);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOk    = 2'd1,
        StWarn  = 2'd2,
        StFault = 2'd3
    } state_e;

    logic [RATE_WIDTH-1:0] rate_min_q, rate_max_q, rate_avg_q;
    logic                  avg_valid_q;
    logic [31:0]           sample_cnt_q;
    logic [RATE_WIDTH-1:0] ring_q [Depth];
    logic [AVG_LOG2-1:0]   wp_q;
    logic [FillW-1:0]      fill_q;
    logic [SumW-1:0]       sum_q;

    state_e                state_q;
    logic [RunW-1:0]       bad_run_q, good_run_q;
    logic                  alarm_q, alarm_rise_q;

    logic [RATE_WIDTH-1:0] base_min, base_max, evicted;
    logic [31:0]           base_cnt;
    logic [SumW-1:0]       base_sum, sum_d;
    logic [FillW-1:0]      base_fill, fill_d;
    logic [AVG_LOG2-1:0]   base_wp;
    logic                  is_bad;

    // A coincident clear is applied first, so the sample lands on an empty history.
    always_comb begin
        base_min  = stats_clear ? '1 : rate_min_q;
        base_max  = stats_clear ? '0 : rate_max_q;
        base_cnt  = stats_clear ? '0 : sample_cnt_q;
        base_sum  = stats_clear ? '0 : sum_q;
        base_fill = stats_clear ? '0 : fill_q;
        base_wp   = stats_clear ? '0 : wp_q;
        evicted   = stats_clear ? '0 : ring_q[wp_q];
        sum_d     = base_sum - SumW'(evicted) + SumW'(rate_in);
        fill_d    = (base_fill == FillFull) ? base_fill : base_fill + FillW'(1);
        is_bad    = rate_in < thresh_low;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || stats_clear) begin
            rate_min_q   <= '1;
            rate_max_q   <= '0;
            rate_avg_q   <= '0;
            avg_valid_q  <= 1'b0;
            sample_cnt_q <= '0;
            wp_q         <= '0;
            fill_q       <= '0;
            sum_q        <= '0;
            for (int i = 0; i < Depth; i++) begin
                ring_q[i] <= '0;
            end
        end
        if (rst_n && rate_valid) begin
            rate_min_q      <= (rate_in < base_min) ? rate_in : base_min;
            rate_max_q      <= (rate_in > base_max) ? rate_in : base_max;
            sample_cnt_q    <= (base_cnt == '1) ? base_cnt : base_cnt + 32'd1;
            sum_q           <= sum_d;
            ring_q[base_wp] <= rate_in;
            wp_q            <= base_wp + AVG_LOG2'(1);
            fill_q          <= fill_d;
            if (fill_d == FillFull) begin
                rate_avg_q  <= RATE_WIDTH'(sum_d >> AVG_LOG2);
                avg_valid_q <= 1'b1;
            end else begin
                rate_avg_q  <= '0;
                avg_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bad_run_q    <= '0;
            good_run_q   <= '0;
            alarm_q      <= 1'b0;
            alarm_rise_q <= 1'b0;
        end else begin
            alarm_rise_q <= 1'b0;
            if (rate_valid) begin
                unique case (state_q)
                    StIdle, StOk: begin
                        if (is_bad) begin
                            bad_run_q <= RunW'(1);
                            if (FAIL_COUNT == 1) begin
                                state_q      <= StFault;
                                alarm_q      <= 1'b1;
                                alarm_rise_q <= 1'b1;
                            end else begin
                                state_q <= StWarn;
                            end
                        end else begin
                            state_q <= StOk;
                        end
                    end
                    StWarn: begin
                        if (!is_bad) begin
                            state_q   <= StOk;
                            bad_run_q <= '0;
                        end else if (bad_run_q + RunW'(1) == FailRun) begin
                            state_q      <= StFault;
                            bad_run_q    <= '0;
                            alarm_q      <= 1'b1;
                            alarm_rise_q <= 1'b1;
                        end else begin
                            bad_run_q <= bad_run_q + RunW'(1);
                        end
                    end
                    StFault: begin
                        // Any bad window restarts the recovery count.
                        if (is_bad) begin
                            good_run_q <= '0;
                        end else if (good_run_q + RunW'(1) == RecoverRun) begin
                            state_q    <= StOk;
                            good_run_q <= '0;
                            alarm_q    <= 1'b0;
                        end else begin
                            good_run_q <= good_run_q + RunW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rate_min   = rate_min_q;
    assign rate_max   = rate_max_q;
    assign rate_avg   = rate_avg_q;
    assign avg_valid  = avg_valid_q;
    assign sample_cnt = sample_cnt_q;
    assign state      = state_q;
    assign alarm      = alarm_q;
    assign alarm_rise = alarm_rise_q;

endmodule
